// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states, default width.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mult_div_pkg;

   localparam int DEFAULT_WIDTH = 32;

   // Op encoding as presented by the control unit.
   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit producing the HI/LO register pair.
// Latency: WIDTH+2 cycles from the start-accept edge to done (1 cycle for a zero divisor with DIVZERO_DETECT_EN).
// Backpressure: none; start is only accepted in IDLE and dropped otherwise (no queuing). Optional: DIVZERO_DETECT_EN.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
`ifdef DIVZERO_DETECT_EN
   output logic             div0,
`endif
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int            CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   state_e               state_q, state_d;
   op_e                  op_q, op_d;
   logic                 sign_a_q, sign_a_d;
   logic                 sign_b_q, sign_b_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   // Multiplicand for multiply, divisor for divide.
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
`ifdef DIVZERO_DETECT_EN
   logic                 div0_q, div0_d;
`endif

   logic                 in_signed;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic                 is_div;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_shift;
   logic                 div_fits;
   logic [WIDTH-1:0]     div_diff;
   logic [2*WIDTH-1:0]   div_next;
   logic                 neg_res;
   logic [2*WIDTH-1:0]   fix_prod;
   logic [WIDTH-1:0]     fix_quo;
   logic [WIDTH-1:0]     fix_rem;

   // Operand magnitudes at accept time and the per-iteration datapath.
   always_comb begin
      in_signed = ~op[0];
      mag_a     = (in_signed && a[WIDTH-1]) ? -a : a;
      mag_b     = (in_signed && b[WIDTH-1]) ? -b : b;
      is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);

      // Shift-add: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

      // Restoring divide: shift the next dividend bit into the remainder and subtract if it fits.
      // The remainder stays below the divisor, so the difference fits in WIDTH bits when taken.
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_fits  = div_shift >= {1'b0, opnd_q};
      div_diff  = div_shift[WIDTH-1:0] - opnd_q;
      div_next  = {(div_fits ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_fits};

      // Sign fix-up; signs are zero for the unsigned ops so nothing is negated there.
      neg_res   = sign_a_q ^ sign_b_q;
      fix_prod  = neg_res ? -acc_q : acc_q;
      fix_quo   = neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      fix_rem   = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   // Sequencer next-state and register updates.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
`ifdef DIVZERO_DETECT_EN
      div0_d   = div0_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d     = op_e'(op);
               sign_a_d = in_signed & a[WIDTH-1];
               sign_b_d = in_signed & b[WIDTH-1];
               cnt_d    = '0;
               if (op[1]) begin
                  acc_d  = {{WIDTH{1'b0}}, mag_a};
                  opnd_d = mag_b;
               end else begin
                  acc_d  = {{WIDTH{1'b0}}, mag_b};
                  opnd_d = mag_a;
               end
               state_d  = ST_CALC;
`ifdef DIVZERO_DETECT_EN
               // Zero divisor short-circuits straight to DONE, leaving HI/LO untouched.
               if (op[1] && (b == '0)) begin
                  state_d = ST_DONE;
                  div0_d  = 1'b1;
               end
`endif
            end
         end
         ST_CALC: begin
            acc_d = is_div ? div_next : mul_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            if (is_div) begin
               lo_d = fix_quo;
               hi_d = fix_rem;
            end else begin
               {hi_d, lo_d} = fix_prod;
            end
            state_d = ST_DONE;
         end
         default: begin
`ifdef DIVZERO_DETECT_EN
            div0_d  = 1'b0;
`endif
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any operation in flight and clears the result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_MULT;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
`ifdef DIVZERO_DETECT_EN
         div0_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
`ifdef DIVZERO_DETECT_EN
         div0_q   <= div0_d;
`endif
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);
   assign hi   = hi_q;
   assign lo   = lo_q;
`ifdef DIVZERO_DETECT_EN
   assign div0 = div0_q;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus randomized ops against an arithmetic reference.
// Latency: checks done arrives 34 cycles after accept (WIDTH=32).
// Backpressure: exercises start while busy and start in the DONE cycle. Optional: DIVZERO_DETECT_EN.
module tb_mult_div_unit;
   import mult_div_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
`ifdef DIVZERO_DETECT_EN
   logic        div0;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
`ifdef DIVZERO_DETECT_EN
      .div0  (div0),
`endif
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference: {hi,lo} from plain signed/unsigned arithmetic (quotient truncates toward zero).
   function automatic logic [63:0] ref_result(input logic [1:0] opc, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (opc)
         2'b00:   return 64'(sx * sy);
         2'b01:   return {32'd0, x} * {32'd0, y};
         2'b10: begin
            if (y == 0) return {x, (sx < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF};
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
      endcase
   endfunction

   // One operation: issue start, scramble inputs after accept, optionally re-pulse start mid-flight,
   // measure latency, check result, then poke start in the DONE cycle and confirm it is dropped.
   task automatic do_op(input logic [1:0] opc, input logic [31:0] av, input logic [31:0] bv,
                        input int restart_at, output logic [63:0] res);
      logic [63:0] exp;
      int          exp_lat;
      int          lat;
      int          extra;
      exp     = ref_result(opc, av, bv);
      exp_lat = 34;
`ifdef DIVZERO_DETECT_EN
      if (opc[1] && bv == 0) begin
         exp     = {hi, lo};
         exp_lat = 1;
      end
`endif
      @(negedge clk);
      start = 1'b1; op = opc; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
      lat = 1;
      while (!done && lat < 100) begin
         if (lat == restart_at) begin
            start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      res = {hi, lo};
      check_eq("latency", 64'(lat), 64'(exp_lat));
      check_eq("result", res, exp);
      check_eq("busy_in_done", 64'(busy), 64'd1);
`ifdef DIVZERO_DETECT_EN
      check_eq("div0", 64'(div0), 64'(opc[1] && bv == 0));
`endif
      start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
      @(negedge clk);
      start = 1'b0;
      check_eq("start_in_done_ignored", 64'(busy), 64'd0);
      check_eq("done_one_cycle", 64'(done), 64'd0);
      check_eq("result_hold", {hi, lo}, res);
      if (restart_at > 0) begin
         extra = 0;
         repeat (40) begin
            @(negedge clk);
            if (done) extra++;
         end
         check_eq("no_queued_start", 64'(extra), 64'd0);
      end
   endtask

   initial begin
      logic [63:0] res;
      logic [1:0]  ropc;
      logic [31:0] ra, rb;
      rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      #12;
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_hilo", {hi, lo}, 64'd0);
      #5 rst_n = 1'b1;

      do_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 0, res);
      check_eq("mult_m1x2", res, 64'hFFFF_FFFF_FFFF_FFFE);
      do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, res);
      check_eq("multu_ffx2", res, 64'h0000_0001_FFFF_FFFE);
      do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, res);
      check_eq("div_m7_2", res, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op(OP_DIVU, 32'd100, 32'd7, 0, res);
      check_eq("divu_100_7", res, {32'd2, 32'd14});
      do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, res);
      check_eq("div_min_m1", res, 64'h0000_0000_8000_0000);
`ifndef DIVZERO_DETECT_EN
      do_op(OP_DIV, 32'd5, 32'd0, 0, res);
      check_eq("div_5_0", res, {32'd5, 32'hFFFF_FFFF});
`else
      do_op(OP_DIV, 32'd5, 32'd0, 0, res);
`endif
      do_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 10, res);

      // Reset at cycle 20 of a MULT: immediate clear, then a DIVU right after release.
      @(negedge clk);
      start = 1'b1; op = OP_MULT; a = 32'd12345; b = 32'd678;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("abort_busy", 64'(busy), 64'd0);
      check_eq("abort_hilo", {hi, lo}, 64'd0);
      repeat (3) @(negedge clk);
      check_eq("abort_hold", {hi, lo}, 64'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      do_op(OP_DIVU, 32'd9, 32'd3, 0, res);
      check_eq("divu_9_3", res, {32'd0, 32'd3});

      for (int i = 0; i < 40; i++) begin
         ropc = 2'($urandom);
         ra   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = 32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         do_op(ropc, ra, rb, 0, res);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
